capture_counter_n: RTL

CAPTURE_COUNTER_N -- requirements
Module: capture_counter_n

---
 rtl/capture_counter_n.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/capture_counter_n.sv
// Switch-capture event counter: debounced push buttons capture, clear and step
// a binary or BCD counter shown on active-low 7-segment digits.
module capture_counter_n #(
   parameter int unsigned SW_W       = 10,
   parameter int unsigned DIGITS     = 2,
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter bit          BCD        = 1'b0,
   parameter bit          WRAP       = 1'b1
) (
   input  logic                clk100_i,
   input  logic                rstn_i,
   input  logic [SW_W-1:0]     sw_i,
   input  logic [2:0]          key_i,
   output logic [SW_W-1:0]     ledr_o,
   output logic [7*DIGITS-1:0] hex_o,
   output logic                ovf_o
);

   localparam int unsigned      CW       = 4 * DIGITS;
   localparam int unsigned      DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [1:0]      r_rst_sync;
   logic            w_rst_n;
   logic [SW_W-1:0] r_sw_s0, r_sw_s1;
   logic [2:0]      w_press;
   logic [SW_W-1:0] r_data;
   logic [CW-1:0]   r_count;
   logic            r_ovf;
   logic [CW-1:0]   w_inc, w_dec;
   logic            w_inc_co, w_dec_bo;

   // Reset asserts immediately but releases two clocks later.
   // NOTE: sequential state always uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) r_rst_sync <= '0;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   for (genvar k = 0; k < 3; k++) begin : g_key
      logic             r_s0, r_s1, r_lvl, r_arm, r_pulse;
      logic [DEB_W-1:0] r_cnt;

      always_ff @(posedge clk100_i or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_lvl   <= 1'b0;
            r_arm   <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_s0    <= ~key_i[k];
            r_s1    <= r_s0;
            r_pulse <= 1'b0;
            if (!r_arm) begin
               // A key held through reset stays ignored until seen released.
               if (r_s1)                   r_cnt <= '0;
               else if (r_cnt == DEB_LAST) begin
                  r_arm <= 1'b1;
                  r_cnt <= '0;
               end else                    r_cnt <= r_cnt + DEB_W'(1);
            end else if (r_s1 == r_lvl) begin
               r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
               r_lvl   <= r_s1;
               r_pulse <= r_s1;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + DEB_W'(1);
            end
         end
      end
      assign w_press[k] = r_pulse;
   end

   always_ff @(posedge clk100_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sw_s0 <= '0;
         r_sw_s1 <= '0;
      end else begin
         r_sw_s0 <= sw_i;
         r_sw_s1 <= r_sw_s0;
      end
   end

   // NOTE: every output of this block is given a default first so no latch
   // can be inferred on any path.
   always_comb begin
      w_inc    = r_count;
      w_dec    = r_count;
      w_inc_co = 1'b1;
      w_dec_bo = 1'b1;
      if (BCD) begin
         for (int d = 0; d < int'(DIGITS); d++) begin
            if (w_inc_co) begin
               if (r_count[4*d +: 4] == 4'd9) w_inc[4*d +: 4] = 4'd0;
               else begin
                  w_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                  w_inc_co        = 1'b0;
               end
            end
            if (w_dec_bo) begin
               if (r_count[4*d +: 4] == 4'd0) w_dec[4*d +: 4] = 4'd9;
               else begin
                  w_dec[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                  w_dec_bo        = 1'b0;
               end
            end
         end
      end else begin
         {w_inc_co, w_inc} = {1'b0, r_count} + (CW+1)'(1);
         w_dec             = r_count - CW'(1);
         w_dec_bo          = (r_count == '0);
      end
   end

   // Carry/borrow out of the top digit marks a boundary; wrapped values are
   // exactly 0 and maximum, so saturating just means holding the register.
   always_ff @(posedge clk100_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_data  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (w_press[1]) begin
         r_data  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_press[0]) r_data <= r_sw_s1;
         if (w_press[0] && !w_press[2]) begin
            if (!w_inc_co || WRAP) r_count <= w_inc;
            if (w_inc_co)          r_ovf   <= 1'b1;
         end else if (w_press[2] && !w_press[0]) begin
            if (!w_dec_bo || WRAP) r_count <= w_dec;
            if (w_dec_bo)          r_ovf   <= 1'b1;
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b1000110;
         4'hD:    return 7'b0100001;
         4'hE:    return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   for (genvar d = 0; d < DIGITS; d++) begin : g_hex
      assign hex_o[7*d +: 7] = seg7(r_count[4*d +: 4]);
   end

   assign ledr_o = r_data;
   assign ovf_o  = r_ovf;

endmodule
